// File: rtl/ser_pkg.sv
// ser_pkg: shared state type, widths and defaults for serial_feed.
// SER_PARITY_EN adds the PAR state to ser_state_t.
package ser_pkg;

  localparam int   DEF_WIDTH      = 8;
  localparam logic DEF_IDLE_LEVEL = 1'b1;

  function automatic int cnt_w(input int w);
    return $clog2(w + 2);
  endfunction

  localparam int DEF_CNT_W = cnt_w(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef SER_PARITY_EN
    ,
    PAR
`endif
  } ser_state_t;

endpackage

// File: rtl/serial_feed_if.sv
// serial_feed_if: parallel word valid/ready handshake into serial_feed.
// master drives din/din_valid, slave returns din_ready.
interface serial_feed_if
  import ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );

endinterface

// File: rtl/ser_hold_reg.sv
// ser_hold_reg: one-word skid buffer ahead of the shifter.
// din_ready depends only on the registered full flag.
module ser_hold_reg
  import ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             load,
  output logic [WIDTH-1:0] hold,
  output logic             full
);

  logic accept;

  assign din_ready = ~full;
  assign accept    = din_valid & ~full;

  // accept needs ~full and load needs full, so they never coincide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      hold <= '0;
    end else if (accept) begin
      full <= 1'b1;
      hold <= din;
    end else if (load) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_feed.sv
// serial_feed: MSB-first parallel-to-serial feeder for the detector.
// SER_PARITY_EN appends an even-parity bit after each word.
module serial_feed
  import ser_pkg::*;
#(
  parameter int   WIDTH      = DEF_WIDTH,
  parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
  input  logic           clk,
  input  logic           rst,
  serial_feed_if.slave   bus,
  output logic           x,
  output logic           x_valid,
  output logic           frame_start,
  output logic           busy
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t       state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d, hold;
  logic [CW-1:0]    cnt, cnt_d;
  logic             hold_full, load;
  logic             x_d, xv_d, fs_d;
`ifdef SER_PARITY_EN
  logic             par, par_d;
`endif

  ser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .din       (bus.din),
    .din_valid (bus.din_valid),
    .din_ready (bus.din_ready),
    .load      (load),
    .hold      (hold),
    .full      (hold_full)
  );

  assign busy = hold_full | (state != IDLE);

  always_comb begin
    state_d = state;
    sreg_d  = sreg;
    cnt_d   = cnt;
    load    = 1'b0;
    x_d     = IDLE_LEVEL;
    xv_d    = 1'b0;
    fs_d    = 1'b0;
`ifdef SER_PARITY_EN
    par_d   = par;
`endif
    unique case (state)
      IDLE: begin
        if (hold_full) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        x_d    = sreg[WIDTH-1];
        xv_d   = 1'b1;
        fs_d   = (cnt == '0);
        sreg_d = sreg << 1;
        cnt_d  = cnt + 1'b1;
        if (cnt == LAST) begin
`ifdef SER_PARITY_EN
          state_d = PAR;
`else
          if (hold_full) load = 1'b1;
          else state_d = IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PAR: begin
        x_d  = par;
        xv_d = 1'b1;
        if (hold_full) begin
          load    = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // a reload always restarts the word, whichever state triggered it
    if (load) begin
      sreg_d = hold;
      cnt_d  = '0;
`ifdef SER_PARITY_EN
      par_d  = ^hold;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sreg        <= '0;
      cnt         <= '0;
      x           <= IDLE_LEVEL;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
`ifdef SER_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      sreg        <= sreg_d;
      cnt         <= cnt_d;
      x           <= x_d;
      x_valid     <= xv_d;
      frame_start <= fs_d;
`ifdef SER_PARITY_EN
      par         <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_feed.sv
// tb_serial_feed: directed checks of serial_feed at WIDTH=8 and WIDTH=1.
// Honours SER_PARITY_EN when the build defines it.
module tb_serial_feed;
  import ser_pkg::*;

`ifdef SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_feed_if #(.WIDTH(8)) a ();
  serial_feed_if #(.WIDTH(1)) b ();

  logic ax, axv, afs, abusy;
  logic bx, bxv, bfs, bbusy;

  serial_feed #(.WIDTH(8), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(a.slave),
    .x(ax), .x_valid(axv), .frame_start(afs), .busy(abusy)
  );

  serial_feed #(.WIDTH(1), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(b.slave),
    .x(bx), .x_valid(bxv), .frame_start(bfs), .busy(bbusy)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rec = 1'b0;
  logic abits[$];
  logic afsq[$];
  int   acyc[$];
  logic bbits[$];
  logic bfsq[$];
  logic exp_b[$];
  logic exp_f[$];
  int   acc_cyc[$];
  bit   saw_low;

  always @(negedge clk) begin
    if (rec) begin
      if (axv) begin
        abits.push_back(ax);
        afsq.push_back(afs);
        acyc.push_back(cyc);
      end
      if (bxv) begin
        bbits.push_back(bx);
        bfsq.push_back(bfs);
      end
    end
  end

  task automatic clear_all();
    abits.delete(); afsq.delete(); acyc.delete();
    bbits.delete(); bfsq.delete();
    exp_b.delete(); exp_f.delete(); acc_cyc.delete();
    saw_low = 1'b0;
  endtask

  task automatic exp_word(input int w, input logic [7:0] v);
    logic p;
    p = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      exp_b.push_back(v[i]);
      exp_f.push_back(i == w - 1);
      p = p ^ v[i];
    end
    if (PB == 1) begin
      exp_b.push_back(p);
      exp_f.push_back(1'b0);
    end
  endtask

  task automatic send(input bit sel, input logic [7:0] w);
    int n;
    n = 0;
    @(negedge clk);
    if (sel) begin b.din = w[0]; b.din_valid = 1'b1; end
    else begin a.din = w; a.din_valid = 1'b1; end
    while (!(sel ? b.din_ready : a.din_ready) && n < 64) begin
      if (!sel) saw_low = 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      tests++; fails++;
      $display("FAIL send_timeout ready=0 after %0d cycles, need ready=1", n);
    end else begin
      @(posedge clk);
      #1;
      acc_cyc.push_back(cyc);
    end
  endtask

  task automatic record(input int n);
    rec = 1'b1;
    repeat (n) @(negedge clk);
    #1 rec = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({ax, axv, afs} !== 3'b100) begin
      fails++; $display("FAIL reset_out got %b need 100", {ax, axv, afs});
    end
    tests++;
    if ({a.din_ready, abusy} !== 2'b10) begin
      fails++; $display("FAIL reset_rdy_busy got %b need 10", {a.din_ready, abusy});
    end
    tests++;
    if ({bx, bxv, bfs, b.din_ready, bbusy} !== 5'b10010) begin
      fails++; $display("FAIL reset_w1 got %b need 10010", {bx, bxv, bfs, b.din_ready, bbusy});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] w;
    logic ex, ev, ef;
    w = 8'hA5;
    a.din = w; a.din_valid = 1'b1;
    @(posedge clk);
    #1 a.din_valid = 1'b0; a.din = 8'h00;
    for (int k = 1; k <= 12 + PB; k++) begin
      @(negedge clk);
      ev = 1'b0; ex = 1'b1; ef = 1'b0;
      if (k >= 3 && k <= 10) begin ev = 1'b1; ex = w[10-k]; ef = (k == 3); end
      if (PB == 1 && k == 11) begin ev = 1'b1; ex = 1'b0; end
      tests++;
      if ({ax, axv, afs} !== {ex, ev, ef}) begin
        fails++;
        $display("FAIL single_c%0d x/v/fs got %b need %b", k, {ax, axv, afs}, {ex, ev, ef});
      end
      if (k == 1) begin
        tests++;
        if (abusy !== 1'b1) begin fails++; $display("FAIL single_busy got %b need 1", abusy); end
      end
    end
    tests++;
    if (abusy !== 1'b0) begin fails++; $display("FAIL single_idle_busy got %b need 0", abusy); end
  endtask

  task automatic test_back_to_back();
    clear_all();
    exp_word(8, 8'h0F);
    exp_word(8, 8'hF0);
    fork
      begin send(1'b0, 8'h0F); send(1'b0, 8'hF0); a.din_valid = 1'b0; end
      record(40);
    join
    tests++;
    if (abits.size() != exp_b.size()) begin
      fails++; $display("FAIL b2b_len got %0d need %0d", abits.size(), exp_b.size());
    end else begin
      for (int i = 0; i < exp_b.size(); i++) begin
        tests++;
        if ({abits[i], afsq[i]} !== {exp_b[i], exp_f[i]}) begin
          fails++;
          $display("FAIL b2b_bit%0d got %b need %b", i, {abits[i], afsq[i]}, {exp_b[i], exp_f[i]});
        end
      end
      tests++;
      if (acyc[acyc.size()-1] - acyc[0] != exp_b.size() - 1) begin
        fails++;
        $display("FAIL b2b_gap span got %0d need %0d", acyc[acyc.size()-1] - acyc[0], exp_b.size() - 1);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_all();
    exp_word(8, 8'h3C);
    exp_word(8, 8'h99);
    exp_word(8, 8'h6E);
    fork
      begin
        send(1'b0, 8'h3C); send(1'b0, 8'h99); send(1'b0, 8'h6E);
        a.din_valid = 1'b0;
      end
      record(50);
    join
    tests++;
    if (saw_low !== 1'b1) begin fails++; $display("FAIL bp_ready_low got %b need 1", saw_low); end
    tests++;
    if (acc_cyc.size() != 3) begin
      fails++; $display("FAIL bp_accepts got %0d need 3", acc_cyc.size());
    end else begin
      tests++;
      if (acc_cyc[1] - acc_cyc[0] != 2) begin
        fails++; $display("FAIL bp_acc2 gap got %0d need 2", acc_cyc[1] - acc_cyc[0]);
      end
      tests++;
      if (acc_cyc[2] - acc_cyc[0] != 10 + PB) begin
        fails++; $display("FAIL bp_acc3 gap got %0d need %0d", acc_cyc[2] - acc_cyc[0], 10 + PB);
      end
    end
    tests++;
    if (abits.size() != exp_b.size()) begin
      fails++; $display("FAIL bp_len got %0d need %0d", abits.size(), exp_b.size());
    end else begin
      for (int i = 0; i < exp_b.size(); i++) begin
        tests++;
        if ({abits[i], afsq[i]} !== {exp_b[i], exp_f[i]}) begin
          fails++;
          $display("FAIL bp_bit%0d got %b need %b", i, {abits[i], afsq[i]}, {exp_b[i], exp_f[i]});
        end
      end
      tests++;
      if (acyc[acyc.size()-1] - acyc[0] != exp_b.size() - 1) begin
        fails++;
        $display("FAIL bp_gap span got %0d need %0d", acyc[acyc.size()-1] - acyc[0], exp_b.size() - 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_all();
    rec = 1'b1;
    send(1'b0, 8'hFF);
    a.din_valid = 1'b0;
    n = 0;
    while (abits.size() < 4 && n < 20) begin @(negedge clk); n++; end
    tests++;
    if (abits.size() != 4) begin
      fails++; $display("FAIL rmid_bit4 got %0d bits need 4", abits.size());
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({ax, axv, afs, abusy, a.din_ready} !== 5'b10001) begin
      fails++;
      $display("FAIL rmid_async got %b need 10001", {ax, axv, afs, abusy, a.din_ready});
    end
    rec = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clear_all();
    exp_word(8, 8'h81);
    fork
      begin send(1'b0, 8'h81); a.din_valid = 1'b0; end
      record(20);
    join
    tests++;
    if (abits.size() != exp_b.size()) begin
      fails++; $display("FAIL rmid_len got %0d need %0d", abits.size(), exp_b.size());
    end else begin
      for (int i = 0; i < exp_b.size(); i++) begin
        tests++;
        if ({abits[i], afsq[i]} !== {exp_b[i], exp_f[i]}) begin
          fails++;
          $display("FAIL rmid_bit%0d got %b need %b", i, {abits[i], afsq[i]}, {exp_b[i], exp_f[i]});
        end
      end
    end
  endtask

  task automatic test_width1();
    clear_all();
    exp_word(1, 8'h01);
    exp_word(1, 8'h00);
    exp_word(1, 8'h01);
    fork
      begin
        send(1'b1, 8'h01); send(1'b1, 8'h00); send(1'b1, 8'h01);
        b.din_valid = 1'b0;
      end
      record(30);
    join
    tests++;
    if (bbits.size() != exp_b.size()) begin
      fails++; $display("FAIL w1_len got %0d need %0d", bbits.size(), exp_b.size());
    end else begin
      for (int i = 0; i < exp_b.size(); i++) begin
        tests++;
        if ({bbits[i], bfsq[i]} !== {exp_b[i], exp_f[i]}) begin
          fails++;
          $display("FAIL w1_bit%0d got %b need %b", i, {bbits[i], bfsq[i]}, {exp_b[i], exp_f[i]});
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a.din = '0; a.din_valid = 1'b0;
    b.din = '0; b.din_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_width1();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
